// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed common-anode 7-segment scan controller with frame-synchronous value commit.
// Define SEG_SCAN_LZB_EN to enable leading-zero blanking.
module seg_scan_ctrl #(
  parameter int DIGITS  = 4,
  parameter int CLK_DIV = 50000,
  parameter int GUARD   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  blank_all,
  output logic [3:0]            hex,
  output logic [DIGITS-1:0]     dig_n,
  output logic                  frame_done
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [4*DIGITS-1:0]   r_shown;
  logic [4*DIGITS-1:0]   r_pend;
  logic                  r_pend_vld;
  logic                  w_tick;
  logic                  w_bnd;
  logic [DIGITS-1:0]     w_elig;
  logic [DIGITS-1:0]     w_dig_n;
  assign w_tick = r_cnt == CW'(CLK_DIV - 1);
  assign w_bnd  = w_tick && r_idx == IW'(DIGITS - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_shown    <= '0;
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick) r_idx <= w_bnd ? '0 : r_idx + 1'b1;
      // a load coinciding with the boundary bypasses the buffer and drops any older pending value
      if (w_bnd) begin
        if (load) r_shown <= value;
        else if (r_pend_vld) r_shown <= r_pend;
        r_pend_vld <= 1'b0;
      end else if (load) begin
        r_pend     <= value;
        r_pend_vld <= 1'b1;
      end
    end
  end
`ifdef SEG_SCAN_LZB_EN
  logic w_nz;
  // digit k is eligible once any nibble at or above k is non-zero; digit 0 always is
  always_comb begin
    w_nz   = 1'b0;
    w_elig = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      w_nz      = w_nz | (|r_shown[4*k +: 4]);
      w_elig[k] = w_nz | (k == 0);
    end
  end
`else
  assign w_elig = '1;
`endif
  always_comb begin
    w_dig_n = '1;
    if (int'(r_cnt) >= GUARD && !blank_all && w_elig[r_idx]) w_dig_n[r_idx] = 1'b0;
  end
  assign hex        = r_shown[4*r_idx +: 4];
  assign dig_n      = w_dig_n;
  assign frame_done = w_bnd;
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Multiplexed scan controller for a common-anode multi-digit 7-segment display.
- Holds a DIGITS-nibble display value and time-slices it one digit at a time. It drives the 4-bit `hex` input of the hex-to-7-segment decoder and the active-low digit enables.
- New values are double-buffered and applied only at frame boundaries, so a frame never mixes old and new digits.

Parameters:
- DIGITS, 4, number of display digits; valid range 1..8.
- CLK_DIV, 50000, clock cycles per digit slot; must be greater than GUARD.
- GUARD, 2, cycles at the start of each slot with all digits disabled (anti-ghosting dead time); 0 disables it.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- load  input  1  one-cycle strobe; captures `value` into the pending buffer.
- value  input  4*DIGITS  display value; nibble k drives digit k; digit 0 is least significant.
- blank_all  input  1  forces all digit enables inactive while high.
- hex  output  4  nibble for the current slot, feeding the 7-segment decoder.
- dig_n  output  DIGITS  active-low digit enables; at most one bit low at any time.
- frame_done  output  1  one-cycle pulse on the last cycle of each full scan.

Behaviour:
- Reset is asynchronous, active-low, and may occur at any time. It clears:
  - prescaler cnt=0, digit index idx=0;
  - shown=0, pend=0, pend_vld=0;
  - outputs: hex=0, dig_n=all ones, frame_done=0.
- Cycle 0 is the first rising edge with rst_n high.
- Prescaler:
  - cnt counts 0..CLK_DIV-1 and wraps to 0.
  - tick = (cnt==CLK_DIV-1).
- Digit index:
  - idx advances on tick, wrapping DIGITS-1 -> 0.
  - Slot k of frame f occupies cycles (f*DIGITS+k)*CLK_DIV .. +CLK_DIV-1.
- Frame boundary:
  - boundary = tick && idx==DIGITS-1.
  - frame_done is high exactly on boundary cycles.
- Load path:
  - A load with no boundary in the same cycle sets pend<=value and pend_vld<=1.
  - Repeated loads within one frame: the last one wins.
- Commit at boundary:
  - If pend_vld is set, shown<=pend and pend_vld<=0; the new value is visible from slot 0 of the next frame.
  - If pend_vld is clear, shown is unchanged.
- Load in the same cycle as boundary:
  - shown<=value directly (bypass) and pend_vld<=0.
  - Any older pending value is discarded.
- Outputs are Moore functions of the registered state, with no extra latency:
  - hex = shown[4*idx+3 : 4*idx] for the whole slot, including the guard cycles.
  - dig_n[idx]=0 when cnt>=GUARD and blank_all==0; all other dig_n bits are 1.
  - blank_all does not stop the counters or the commit logic.
- dig_n changes only at slot boundaries and at the GUARD edge. No two digits are ever enabled simultaneously.
- Segment blanking is done only via dig_n. The block never relies on a decoder code for blank, because the decoder has no blank code.

Optional Feature:
- Macro: SEG_SCAN_LZB_EN (leading-zero blanking).
- Defined:
  - Digit k (k>=1) is suppressed (dig_n[k] held 1) when shown nibbles DIGITS-1..k are all zero.
  - Digit 0 is always eligible.
  - Suppression is computed from shown, so it changes only at frame boundaries.
  - hex still carries the nibble (0) during a suppressed slot.
- Not defined:
  - All digits are eligible; leading zeros are displayed as 0.

Test Plan (DIGITS=4, CLK_DIV=8, GUARD=2):
1. Reset and mid-frame reset:
   - Assert rst_n low at cycle 13 -> hex=0, dig_n=4'b1111, frame_done=0 immediately, with no clock needed.
   - After release, slot 0 enables at cycle 2 with hex=0.
2. Deferred commit:
   - load with value=16'h1234 at cycle 3 -> frame 0 shows 0000.
   - frame_done high at cycle 31 only.
   - Cycles 32-39: hex=4, dig_n=4'b1111 at cycles 32-33, dig_n=4'b1110 at cycles 34-39.
   - Slot 1: hex=3, dig_n=4'b1101. Slot 2: hex=2. Slot 3: hex=1.
3. Last load wins:
   - load 16'hAAAA at cycle 5, then 16'h5B0C at cycle 20 -> frame 1 digits 0..3 show C,0,B,5.
   - 16'hAAAA is never displayed.
4. Boundary bypass:
   - load 16'h00FF at cycle 10, then load 16'h9876 at cycle 31 -> cycle 32 hex=6; 16'h00FF is never displayed.
   - At the next boundary, shown is unchanged and pend_vld=0.
5. blank_all:
   - Hold blank_all=1 over cycles 40-60 -> dig_n=4'b1111 throughout; hex keeps sequencing.
   - frame_done still pulses at cycle 63. Normal enables resume the cycle after blank_all drops.
6. Leading-zero blanking:
   - Commit value=16'h0050.
   - With SEG_SCAN_LZB_EN: dig_n[3] and dig_n[2] stay 1; digit 1 shows 5; digit 0 shows 0 with dig_n[0]=0.
   - Without the macro: all four digits are enabled in turn.
   - value=16'h0000 with the macro: only digit 0 is enabled.
